// File: rtl/mem_agen_pkg.sv
// mem_agen_pkg: shared widths, control-store bit positions and FSM states for the address-generation stage.
package mem_agen_pkg;
  localparam int VPN_W = 20;
  localparam int PPN_W = 3;
  localparam int PA_W = 15;
  localparam int CS_W = 49;
  localparam int CS_MEMREN = 4;
  localparam int CS_MEMWEN = 8;
  typedef enum logic {IDLE, SPLIT} state_e;
endpackage

// File: rtl/mem_agen_stage_tlb_cam.sv
// tlb_cam: fully associative translation storage with one fill port and two combinational lookup ports.
module tlb_cam #(
  parameter int NENT = 8,
  parameter int VPNW = 20,
  parameter int PPNW = 3,
  parameter int IW = $clog2(NENT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we_i,
  input  logic [IW-1:0]   widx_i,
  input  logic [VPNW-1:0] wvpn_i,
  input  logic [PPNW-1:0] wppn_i,
  input  logic            wvalid_i,
  input  logic [VPNW-1:0] vpn0_i,
  input  logic [VPNW-1:0] vpn1_i,
  output logic            hit0_o,
  output logic [PPNW-1:0] ppn0_o,
  output logic            hit1_o,
  output logic [PPNW-1:0] ppn1_o
);
  logic [NENT-1:0] vld_q;
  logic [VPNW-1:0] vpn_q [NENT];
  logic [PPNW-1:0] ppn_q [NENT];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) vld_q <= '0;
    else if (we_i) vld_q[widx_i] <= wvalid_i;
  end
  always_ff @(posedge clk) begin
    if (we_i) begin
      vpn_q[widx_i] <= wvpn_i;
      ppn_q[widx_i] <= wppn_i;
    end
  end
  always_comb begin
    hit0_o = 1'b0;
    ppn0_o = '0;
    hit1_o = 1'b0;
    ppn1_o = '0;
    for (int i = 0; i < NENT; i++) begin
      if (vld_q[i] && vpn_q[i] == vpn0_i) begin
        hit0_o = 1'b1;
        ppn0_o = ppn0_o | ppn_q[i];
      end
      if (vld_q[i] && vpn_q[i] == vpn1_i) begin
        hit1_o = 1'b1;
        ppn1_o = ppn1_o | ppn_q[i];
      end
    end
  end
endmodule

// File: rtl/mem_agen_stage.sv
// mem_agen_stage: VA->PA translation and two-beat split of word-spilling accesses; TLB enabled by MEM_AGEN_TLB_EN.
module mem_agen_stage
  import mem_agen_pkg::*;
#(
  parameter int NENT = 8,
  parameter int VPNW = VPN_W,
  parameter int PPNW = PPN_W,
  parameter int PAW = PPNW + 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_v,
  input  logic [CS_W-1:0]         i_CS,
  input  logic [31:0]             i_EIP,
  input  logic [31:0]             i_va,
  input  logic [1:0]              i_reqSize,
  input  logic                    i_inv,
  input  logic                    mem_stall,
  input  logic                    fill_en,
  input  logic [$clog2(NENT)-1:0] fill_idx,
  input  logic [VPNW-1:0]         fill_vpn,
  input  logic [PPNW-1:0]         fill_ppn,
  input  logic                    fill_valid,
  output logic                    o_v,
  output logic [CS_W-1:0]         o_CS,
  output logic [31:0]             o_EIP,
  output logic [PAW-1:0]          o_phys_addr,
  output logic [1:0]              o_reqSize,
  output logic                    o_spill,
  output logic                    o_false_of,
  output logic                    o_pf,
  output logic                    stall
);
  state_e state_q, state_d;
  logic v_q, v_d, spill_q, spill_d, fof_q, fof_d, pf_q, pf_d;
  logic [CS_W-1:0] cs_q, cs_d;
  logic [31:0] eip_q, eip_d, va_q, va_d, va1;
  logic [PAW-1:0] pa_q, pa_d, pa0, pa1;
  logic [1:0] size_q, size_d, end_q, end_d;
  logic [2:0] end0;
  logic memop, sp, pf0, pf1, go_split;
  assign memop = i_v & (i_CS[CS_MEMREN] | i_CS[CS_MEMWEN]);
  assign end0 = {1'b0, i_va[1:0]} + {1'b0, i_reqSize};
  assign sp = end0[2];
  assign va1 = {va_q[31:2] + 30'd1, 2'b00};
  assign go_split = memop & sp & ~pf0;
`ifdef MEM_AGEN_TLB_EN
  logic hit0, hit1;
  logic [PPNW-1:0] ppn0, ppn1;
  // Flush wins over a same-cycle fill.
  tlb_cam #(.NENT(NENT), .VPNW(VPNW), .PPNW(PPNW)) u_cam (
    .clk(clk), .rst(rst), .we_i(fill_en & ~i_inv), .widx_i(fill_idx),
    .wvpn_i(fill_vpn), .wppn_i(fill_ppn), .wvalid_i(fill_valid),
    .vpn0_i(i_va[31:12]), .vpn1_i(va1[31:12]),
    .hit0_o(hit0), .ppn0_o(ppn0), .hit1_o(hit1), .ppn1_o(ppn1)
  );
  assign pa0 = hit0 ? {ppn0, i_va[11:0]} : '0;
  assign pf0 = ~hit0;
  assign pa1 = hit1 ? {ppn1, va1[11:0]} : '0;
  assign pf1 = ~hit1;
`else
  logic unused_tlb;
  assign unused_tlb = ^{fill_en, fill_idx, fill_vpn, fill_ppn, fill_valid, i_va[31:PAW], va1[31:PAW]};
  assign pa0 = i_va[PAW-1:0];
  assign pf0 = 1'b0;
  assign pa1 = va1[PAW-1:0];
  assign pf1 = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    v_d = v_q;
    cs_d = cs_q;
    eip_d = eip_q;
    pa_d = pa_q;
    size_d = size_q;
    spill_d = spill_q;
    fof_d = fof_q;
    pf_d = pf_q;
    va_d = va_q;
    end_d = end_q;
    if (state_q == SPLIT) begin
      if (!mem_stall) begin
        v_d = 1'b1;
        pa_d = pa1;
        size_d = end_q;
        spill_d = 1'b0;
        fof_d = 1'b0;
        pf_d = pf1;
        state_d = IDLE;
      end
    end else if (!mem_stall) begin
      v_d = i_v;
      cs_d = i_CS;
      eip_d = i_EIP;
      pa_d = memop ? pa0 : '0;
      size_d = go_split ? 2'd3 - i_va[1:0] : i_reqSize;
      spill_d = go_split;
      fof_d = memop & ~sp & (i_va[1:0] != 2'd0);
      pf_d = memop & pf0;
      va_d = i_va;
      end_d = end0[1:0];
      state_d = go_split ? SPLIT : IDLE;
    end
    if (i_inv) begin
      v_d = 1'b0;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      v_q <= 1'b0;
      cs_q <= '0;
      eip_q <= '0;
      pa_q <= '0;
      size_q <= '0;
      spill_q <= 1'b0;
      fof_q <= 1'b0;
      pf_q <= 1'b0;
      va_q <= '0;
      end_q <= '0;
    end else begin
      state_q <= state_d;
      v_q <= v_d;
      cs_q <= cs_d;
      eip_q <= eip_d;
      pa_q <= pa_d;
      size_q <= size_d;
      spill_q <= spill_d;
      fof_q <= fof_d;
      pf_q <= pf_d;
      va_q <= va_d;
      end_q <= end_d;
    end
  end
  assign stall = mem_stall | (state_q == SPLIT);
  assign o_v = v_q;
  assign o_CS = cs_q;
  assign o_EIP = eip_q;
  assign o_phys_addr = pa_q;
  assign o_reqSize = size_q;
  assign o_spill = spill_q;
  assign o_false_of = fof_q;
  assign o_pf = pf_q;
endmodule

// File: doc/mem_agen_stage.md
# mem_agen_stage

Address-translation and access-split stage directly upstream of the memory pipe stage. Latches one memory micro-op per cycle and translates its 32-bit virtual address to the 15-bit physical address through an 8-entry fully associative TLB. It splits word-spilling accesses into two sequential beats: the first with `o_spill=1`, the second with the next word's address. It stalls the upstream stage while the split completes and while the memory pipe stalls.

## Interface
- `NENT`, 8: TLB entries (power of two).
- `VPNW`, 20: virtual page-number width (4 KB pages).
- `PPNW`, 3: physical page-number width (15-bit PA).
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-low reset.
- `i_v`  in  1  incoming micro-op valid.
- `i_CS`  in  49  control store word, passed through; `i_CS[4]`=memRen, `i_CS[8]`=memWen.
- `i_EIP`  in  32  passed through.
- `i_va`  in  32  virtual address.
- `i_reqSize`  in  2  access bytes minus one.
- `i_inv`  in  1  pipeline flush.
- `mem_stall`  in  1  memory pipe cannot accept this cycle.
- `fill_en`  in  1  TLB write strobe.
- `fill_idx`  in  3  entry to write.
- `fill_vpn`  in  20  entry VPN.
- `fill_ppn`  in  3  entry PPN.
- `fill_valid`  in  1  entry valid bit.
- `o_v`  out  1  output beat valid.
- `o_CS`  out  49  registered control word.
- `o_EIP`  out  32  registered EIP.
- `o_phys_addr`  out  15  beat physical address.
- `o_reqSize`  out  2  beat bytes minus one.
- `o_spill`  out  1  first beat of a split access.
- `o_false_of`  out  1  unaligned access contained in one word.
- `o_pf`  out  1  translation fault on this beat.
- `stall`  out  1  upstream must hold.

## Operation
- **Memory op:** `i_v & (memRen|memWen)`. Non-memory ops pass through with `o_phys_addr=0`, `o_spill=0`, `o_pf=0`.
- **End offset:** `end = {1'b0,va[1:0]} + {1'b0,reqSize}`, 3 bits.
- **Spill:** `spill = end[2]`.
- **False overflow:** `false_of = ~spill & (va[1:0]!=0)`.
- **Lookup:** match valid entry whose VPN equals `va[31:12]`; `PA = {ppn, va[11:0]}`.
- **Miss:** `o_pf=1`, `o_phys_addr=0`, `o_v=1`. A spilled op that misses on beat0 emits only that faulting beat and is not split.
- **FSM states:**
  - IDLE to SPLIT: a spilled op is accepted and its beat0 hits.
  - SPLIT to IDLE: the memory pipe accepts beat0 (`~mem_stall`).
- **Beat0:** `o_spill=1`, `o_reqSize = 3 - va[1:0]`.
- **Beat1:**
  - `o_spill=0`, `o_reqSize = end[1:0]`.
  - `VA1 = {va[31:2]+1, 2'b00}`, taken from a held copy of VA, translated in SPLIT.
  - If VA1 crosses a page (`va[11:2]` all ones), VA1 needs its own lookup; a miss there sets `o_pf` on beat1.
- **Stall:** `stall = mem_stall | (state==SPLIT)`.
- **Output register:**
  - Holds while `mem_stall`.
  - Otherwise loads the next beat (beat1 in SPLIT, else the incoming op).
  - `o_v=0` if nothing loads.
- **Flush:** `i_inv` at a clock edge clears `o_v` and forces IDLE. Flush overrides `mem_stall` and any fill.
- **TLB fill:** writes entry `fill_idx` at the clock edge. A same-cycle lookup sees the old contents.

## Timing
- Latency: one cycle from acceptance to `o_v`.
- Throughput: one non-spilled op per cycle.
- Spilled op: beat0 at N+1, beat1 at N+2, with no memory-pipe stalls. Upstream is accepted again at the N+2 edge (`stall` is high during cycle N+1).
- Reset: all outputs 0, FSM IDLE, all TLB valid bits 0.
- Reset mid-split abandons beat1.

## Configuration
- `MEM_AGEN_TLB_EN` defined: TLB, fill port and `o_pf` are active as specified.
- `MEM_AGEN_TLB_EN` undefined:
  - Identity map, `PA = va[14:0]`.
  - `o_pf` tied 0.
  - Fill inputs ignored.
  - TLB storage not instantiated.
  - Split behaviour unchanged.

## Structure
- **Package `mem_agen_pkg`:**
  - VPN/PPN/PA widths.
  - CS bit indices for memRen and memWen.
  - FSM state enum (IDLE, SPLIT).
- **Sub-module `tlb_cam`:**
  - Storage and fill write port.
  - Two independent combinational lookup ports (beat0, beat1).
  - Outputs hit and ppn per port.

## Test plan
- **Aligned hit:** fill entry 0 with vpn `0x00012`, ppn 5; issue 4-byte load at va `0x00012340` -> next cycle `o_phys_addr=0x5340`, `o_spill=0`, `o_false_of=0`, `o_pf=0`.
- **In-word unaligned:** 2-byte load at va `0x00012341` -> `o_false_of=1`, `o_reqSize=1`, single beat.
- **Spill:** 4-byte load at va `0x00012342` ->
  - beat0: PA `0x5342`, size 1, `o_spill=1`;
  - beat1: PA `0x5344`, size 1;
  - `stall` high for one cycle.
- **Page-cross spill:** entries vpn `0x00012`->ppn 5 and `0x00013`->ppn 6; va `0x00012FFE` size 3 -> beat0 PA `0x5FFE`, beat1 PA `0x6000`. Repeat with the second entry invalid -> beat1 `o_pf=1`.
- **Stall hold:** hold `mem_stall` 3 cycles during beat0 -> outputs stable, `stall=1` throughout; beat1 follows release.
- **Flush and reset:** assert `i_inv` in SPLIT -> `o_v=0`, FSM IDLE next cycle. Pulse `rst` low mid-stream -> all outputs 0 immediately and TLB misses afterwards.
